// File: rtl/jpeg_byte_unstuffer_pkg.sv
// Shared definitions for the JPEG scan-data unstuffer: bus width, marker bytes, FSM states.
package jpeg_byte_unstuffer_pkg;

    localparam int IN_BUS_WIDTH   = 32;
    localparam int PERIOD         = 10;
    localparam int BYTES_PER_WORD = IN_BUS_WIDTH / 8;

    localparam logic [7:0] FILL_BYTE     = 8'hFF;
    localparam logic [7:0] MARKER_PREFIX = 8'hFF;
    localparam logic [7:0] STUFF_BYTE    = 8'h00;
    localparam logic [7:0] RST0          = 8'hD0;
    localparam logic [7:0] RST7          = 8'hD7;
    localparam logic [7:0] EOI           = 8'hD9;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        SAW_FF = 2'd1,
        HALT   = 2'd2
    } unstuff_state_e;

    function automatic logic is_rst_marker(input logic [7:0] code);
        return (code >= RST0) && (code <= RST7);
    endfunction

endpackage

// File: rtl/jpeg_byte_unstuffer_word_packer.sv
// Packs bytes MSB-first into words, double-buffered by a holding register that feeds the
// decoder's request/valid handshake at most one word every two cycles.
module jpeg_word_packer
    import jpeg_byte_unstuffer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    app_vld,
    input  logic [7:0]              app_byte,
    input  logic                    flush,
    input  logic                    clear_cnt,
    input  logic                    request,
    output logic                    slot_free,
    output logic [IN_BUS_WIDTH-1:0] data_out,
    output logic                    valid_out
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BYTES_PER_WORD);

    logic [IN_BUS_WIDTH-1:0] acc_q, acc_d;
    logic [IN_BUS_WIDTH-1:0] hold_q, hold_d;
    logic [IN_BUS_WIDTH-1:0] data_out_q, data_out_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    hold_full_q, hold_full_d;
    logic                    valid_out_q, valid_out_d;
    logic                    deliver;
    logic                    transfer;

    always_comb begin
        deliver  = request && hold_full_q && !valid_out_q;
        transfer = (cnt_q == CNT_FULL) && (!hold_full_q || deliver);

        acc_d       = acc_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        data_out_d  = data_out_q;
        valid_out_d = deliver;

        if (deliver) begin
            data_out_d  = hold_q;
            hold_full_d = 1'b0;
        end

        // Transfer first so a byte arriving in the same cycle starts the next word.
        if (transfer) begin
            hold_d      = acc_q;
            hold_full_d = 1'b1;
            cnt_d       = '0;
        end

        if (app_vld) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (cnt_d == CNT_W'(i)) begin
                    acc_d[8*(BYTES_PER_WORD-1-i) +: 8] = app_byte;
                end
            end
            cnt_d = cnt_d + CNT_W'(1);
        end

        if (flush && (cnt_d != '0)) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (CNT_W'(i) >= cnt_d) begin
                    acc_d[8*(BYTES_PER_WORD-1-i) +: 8] = FILL_BYTE;
                end
            end
            cnt_d = CNT_FULL;
        end

        // A flushed word still waiting for the holding register is not a partial; keep it.
        if (clear_cnt && (cnt_d != CNT_FULL)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign slot_free = (cnt_q != CNT_FULL) || !hold_full_q || deliver;
    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;

endmodule

// File: rtl/jpeg_byte_unstuffer.sv
// Removes 0xFF00 stuffing from a JPEG scan stream, reports markers, and halts on any
// non-restart marker until resumed; word packing/delivery lives in jpeg_word_packer.
module jpeg_byte_unstuffer
    import jpeg_byte_unstuffer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              byte_in,
    input  logic                    byte_valid,
    output logic                    byte_ready,
    input  logic                    resume,
    input  logic                    request,
    output logic [IN_BUS_WIDTH-1:0] data_out,
    output logic                    valid_out,
    output logic                    marker_valid,
    output logic [7:0]              marker_code,
    output logic                    halted
);

    unstuff_state_e state_q, state_d;
    logic           marker_valid_q, marker_valid_d;
    logic [7:0]     marker_code_q, marker_code_d;
    logic           slot_free;
    logic           accept;
    logic           app_vld;
    logic [7:0]     app_byte;
    logic           flush;
    logic           clear_cnt;

    assign byte_ready = (state_q != HALT) && slot_free;
    assign accept     = byte_valid && byte_ready;

    always_comb begin
        state_d        = state_q;
        app_vld        = 1'b0;
        app_byte       = byte_in;
        flush          = 1'b0;
        clear_cnt      = 1'b0;
        marker_valid_d = 1'b0;
        marker_code_d  = marker_code_q;

        case (state_q)
            NORMAL: begin
                if (accept) begin
                    if (byte_in == MARKER_PREFIX) begin
                        state_d = SAW_FF;
                    end else begin
                        app_vld = 1'b1;
                    end
                end
            end
            SAW_FF: begin
                if (accept) begin
                    if (byte_in == STUFF_BYTE) begin
                        app_vld  = 1'b1;
                        app_byte = MARKER_PREFIX;
                        state_d  = NORMAL;
                    end else if (byte_in != MARKER_PREFIX) begin
                        // Runs of FF are fill; anything else here is a marker code.
                        flush          = 1'b1;
                        marker_valid_d = 1'b1;
                        marker_code_d  = byte_in;
                        state_d        = is_rst_marker(byte_in) ? NORMAL : HALT;
                    end
                end
            end
            HALT: begin
                if (resume) begin
                    state_d   = NORMAL;
                    clear_cnt = 1'b1;
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= NORMAL;
            marker_valid_q <= 1'b0;
            marker_code_q  <= 8'h00;
        end else begin
            state_q        <= state_d;
            marker_valid_q <= marker_valid_d;
            marker_code_q  <= marker_code_d;
        end
    end

    assign marker_valid = marker_valid_q;
    assign marker_code  = marker_code_q;
    assign halted       = (state_q == HALT);

    jpeg_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .app_vld   (app_vld),
        .app_byte  (app_byte),
        .flush     (flush),
        .clear_cnt (clear_cnt),
        .request   (request),
        .slot_free (slot_free),
        .data_out  (data_out),
        .valid_out (valid_out)
    );

endmodule

// File: tb/tb_jpeg_byte_unstuffer.sv
// Scoreboard bench: a stream-level unstuffing model queues expected words/markers, a monitor checks them.
module tb_jpeg_byte_unstuffer;
    import jpeg_byte_unstuffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        resume;
    logic        request;
    logic [31:0] data_out;
    logic        valid_out;
    logic        marker_valid;
    logic [7:0]  marker_code;
    logic        halted;

    always #(PERIOD/2) clk = ~clk;

    jpeg_byte_unstuffer dut (
        .clk          (clk),
        .rst          (rst),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .resume       (resume),
        .request      (request),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .marker_valid (marker_valid),
        .marker_code  (marker_code),
        .halted       (halted)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int vcount  = 0;
    int acc_count = 0;
    int last_acc_cyc = 0;
    int last_vo_cyc  = 0;
    int req_mode = 0;
    logic prev_vo = 1'b0;

    logic [31:0] exp_word_q[$];
    logic [7:0]  exp_mark_q[$];
    logic [7:0]  pend[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_data(input logic [7:0] b);
        pend.push_back(b);
        if (pend.size() == 4) begin
            exp_word_q.push_back({pend[0], pend[1], pend[2], pend[3]});
            pend.delete();
        end
    endtask

    // Stream-level unstuffing: FF 00 -> data FF, FF (FF)* xx -> marker xx, with 1-fill flush.
    task automatic model_segment(input logic [7:0] seg[$]);
        int i = 0;
        int j;
        while (i < seg.size()) begin
            if (seg[i] != 8'hFF) begin
                model_data(seg[i]);
                i++;
            end else begin
                j = i + 1;
                while (j < seg.size() && seg[j] == 8'hFF) j++;
                if (j >= seg.size()) break;
                if (seg[j] == 8'h00) begin
                    model_data(8'hFF);
                end else begin
                    while (pend.size() != 0) model_data(8'hFF);
                    exp_mark_q.push_back(seg[j]);
                end
                i = j + 1;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int  waited = 0;
        bit  done = 0;
        while (!done) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_in    = b;
                #1;
                if (byte_ready) begin
                    @(posedge clk);
                    #1;
                    byte_valid = 1'b0;
                    acc_count++;
                    last_acc_cyc = cyc;
                    done = 1;
                end
            end
            waited++;
            if (!done && waited > 300) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: byte %h not accepted, expected acceptance within 300 cycles", b);
                byte_valid = 1'b0;
                done = 1;
            end
        end
    endtask

    task automatic send_seg(input logic [7:0] seg[$], input bit gaps);
        model_segment(seg);
        foreach (seg[k]) send_byte(seg[k], gaps);
    endtask

    task automatic wait_empty(input int bound);
        int k = 0;
        while ((exp_word_q.size() != 0 || exp_mark_q.size() != 0) && k < bound) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        check("drain_words", exp_word_q.size(), 0);
        check("drain_markers", exp_mark_q.size(), 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a word or marker.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (valid_out) begin
                    vcount++;
                    last_vo_cyc = cyc;
                    check("no_back_to_back", {31'd0, prev_vo}, 32'd0);
                    if (exp_word_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_word: got %h, expected no word", data_out);
                    end else begin
                        check("word", data_out, exp_word_q.pop_front());
                    end
                end
                if (marker_valid) begin
                    if (exp_mark_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_marker: got %h, expected no marker", marker_code);
                    end else begin
                        check("marker_code", {24'd0, marker_code}, {24'd0, exp_mark_q.pop_front()});
                    end
                end
            end
            prev_vo = rst ? 1'b0 : valid_out;
        end
    end

    initial begin
        request = 1'b0;
        forever begin
            @(negedge clk);
            case (req_mode)
                0:       request = 1'b0;
                1:       request = 1'b1;
                default: request = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #(PERIOD * 60000);
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data_out"}, data_out, 32'd0);
        check({tag, "_valid_out"}, {31'd0, valid_out}, 32'd0);
        check({tag, "_marker_valid"}, {31'd0, marker_valid}, 32'd0);
        check({tag, "_marker_code"}, {24'd0, marker_code}, 32'd0);
        check({tag, "_halted"}, {31'd0, halted}, 32'd0);
    endtask

    initial begin
        logic [7:0] seg[$];
        int v0;
        rst = 1'b1;
        byte_valid = 1'b0;
        byte_in = 8'h00;
        resume = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // Plain word with request high; check 2-cycle latency from the 4th accepted byte.
        req_mode = 1;
        seg = '{8'h12, 8'h34, 8'h56, 8'h78};
        send_seg(seg, 1'b0);
        wait_empty(50);
        check("latency", last_vo_cyc - last_acc_cyc, 2);

        seg = '{8'hAB, 8'hFF, 8'h00, 8'hCD, 8'hEF};
        send_seg(seg, 1'b0);
        wait_empty(50);

        seg = '{8'h11, 8'h22, 8'hFF, 8'hD3, 8'h33, 8'h44, 8'h55, 8'h66};
        send_seg(seg, 1'b0);
        wait_empty(50);
        check("rst_marker_not_halted", {31'd0, halted}, 32'd0);

        // Non-restart marker halts intake until resume.
        seg = '{8'h9A, 8'hFF, 8'hFF, EOI};
        send_seg(seg, 1'b0);
        wait_empty(50);
        #1;
        check("eoi_halted", {31'd0, halted}, 32'd1);
        check("eoi_byte_ready", {31'd0, byte_ready}, 32'd0);
        @(negedge clk);
        resume = 1'b1;
        @(posedge clk);
        #1;
        resume = 1'b0;
        check("resume_halted", {31'd0, halted}, 32'd0);
        check("resume_byte_ready", {31'd0, byte_ready}, 32'd1);

        // Backpressure: with no request only acc + hold can be filled.
        req_mode = 0;
        repeat (2) @(negedge clk);
        acc_count = 0;
        fork
            begin
                logic [7:0] bp[$];
                for (int i = 1; i <= 12; i++) bp.push_back(8'(i));
                send_seg(bp, 1'b0);
            end
        join_none
        repeat (30) @(negedge clk);
        #1;
        check("bp_accepted", acc_count, 8);
        check("bp_byte_ready", {31'd0, byte_ready}, 32'd0);
        req_mode = 1;
        wait fork;
        wait_empty(200);

        // Async reset with a partial word in acc and a full hold.
        req_mode = 0;
        seg = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_seg(seg, 1'b0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("async_rst");
        exp_word_q.delete();
        exp_mark_q.delete();
        pend.delete();
        @(negedge clk);
        rst = 1'b0;
        req_mode = 1;
        v0 = vcount;
        seg = '{8'h21, 8'h22, 8'h23, 8'h24};
        send_seg(seg, 1'b0);
        wait_empty(50);
        repeat (6) @(negedge clk);
        check("post_rst_word_count", vcount - v0, 1);

        // Random stream: data, stuffed FFs, fill runs and restart markers, random request/valid gaps.
        req_mode = 2;
        for (int s = 0; s < 15; s++) begin
            seg.delete();
            for (int it = 0; it < 20; it++) begin
                case ($urandom_range(0, 9))
                    7: begin
                        seg.push_back(8'hFF);
                        seg.push_back(8'h00);
                    end
                    8: begin
                        seg.push_back(8'hFF);
                        repeat ($urandom_range(0, 2)) seg.push_back(8'hFF);
                        seg.push_back(RST0 + 8'($urandom_range(0, 7)));
                    end
                    default: seg.push_back(8'($urandom_range(0, 254)));
                endcase
            end
            send_seg(seg, 1'b1);
        end
        seg = '{8'hFF, RST7};
        send_seg(seg, 1'b1);
        wait_empty(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jpeg_byte_unstuffer.md
Name: jpeg_byte_unstuffer

Overview:
- Sits directly upstream of the entropy decoder. Accepts the raw JPEG scan byte stream and removes 0xFF00 byte stuffing.
- Detects markers, packs bytes MSB-first into `IN_BUS_WIDTH-bit words, and hands them out one at a time on the decoder's request/valid handshake.
- Double-buffered: one byte accumulator plus one output holding register, so byte intake overlaps word delivery.

Parameters:
- BYTES_PER_WORD, `IN_BUS_WIDTH/8 (=4), number of bytes packed per output word.
- FILL_BYTE, 8'hFF, pad value for the unused bytes of a partial word flushed at a marker (JPEG 1-fill).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- byte_in  in  8  scan byte from the stream source
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  byte accepted this cycle when byte_valid && byte_ready
- resume  in  1  one-cycle pulse; leaves HALT
- request  in  1  entropy decoder wants a word (level)
- data_out  out  `IN_BUS_WIDTH  packed word; first byte in bits [31:24]
- valid_out  out  1  one-cycle pulse; data_out valid
- marker_valid  out  1  one-cycle pulse; marker byte consumed
- marker_code  out  8  second byte of the marker (e.g. 8'hD9)
- halted  out  1  state==HALT

Behaviour:
- Reset (async):
  - state=NORMAL, acc=0, cnt=0, hold=0, hold_full=0.
  - data_out=0, valid_out=0, marker_valid=0, marker_code=0, halted=0.
- Unstuff FSM (advances only on accepted bytes):
  - NORMAL: byte!=FF -> append byte. byte==FF -> SAW_FF, no append.
  - SAW_FF, byte==00: append FF -> NORMAL.
  - SAW_FF, byte==FF: fill byte, dropped, stay SAW_FF.
  - SAW_FF, byte in D0..D7 (RSTn): flush -> NORMAL.
  - SAW_FF, any other byte: flush -> HALT.
  - In both marker cases: marker_valid=1 and marker_code=byte, registered, in the cycle after acceptance.
  - HALT: byte_ready=0. Pending words are still delivered. On resume: -> NORMAL, with cnt=0.
- Append: acc[8*(3-cnt)+:8] <= byte, cnt++.
- Flush: if cnt>0, fill bytes cnt..3 with FILL_BYTE and set cnt=4. If cnt==0, no word is produced.
- Transfer: when cnt==4 and (!hold_full || delivering this cycle):
  - hold <= acc, hold_full <= 1.
  - cnt <= 0, or cnt <= 1 if a byte is appended in the same cycle.
- byte_ready (combinational): state!=HALT && (cnt<4 || !hold_full || delivering).
- Delivery:
  - Fires when request && hold_full && !valid_out.
  - At the next edge: data_out<=hold, valid_out<=1, hold_full<=0. valid_out drops the following cycle.
  - No back-to-back pulses; max one word per 2 cycles.
  - The consumer deasserts request after seeing valid_out. data_out holds its value until the next delivery.
- Latency: byte completing a word at edge N -> hold_full at N+1 -> valid_out at N+2, if request is high at N+1.
- Simultaneous events:
  - Transfer into a hold being emptied in the same cycle is allowed; no bubble.
  - A resume while not in HALT is ignored.
  - The marker flush and a transfer of the previous word never collide, because a byte is only accepted when a transfer slot exists.
- Reset mid-word: the partial acc and any undelivered hold word are discarded; there is no spurious valid_out.

Decomposition:
- Shared package sys_defs.svh: `IN_BUS_WIDTH and PERIOD (existing).
- Add to sys_defs.svh: JPEG marker constants (MARKER_PREFIX=8'hFF, RST0=8'hD0, RST7=8'hD7, EOI=8'hD9) and the unstuffer state enum (NORMAL, SAW_FF, HALT).
- One sub-module is natural: jpeg_word_packer (acc/cnt/hold registers, transfer and delivery logic). The top holds the FSM and marker outputs.

Test Plan:
- Bytes 12 34 56 78 with request held high -> one valid_out pulse, data_out=32'h12345678, 2 cycles after the 4th byte is accepted.
- Bytes AB FF 00 CD EF -> data_out=32'hABFFCDEF; the stuffed 00 is removed; no marker_valid.
- Bytes 11 22 FF D3 33 44 55 66 -> words 32'h1122FFFF then 32'h33445566; marker_valid with marker_code=D3; state returns to NORMAL.
- Bytes 9A FF FF D9 -> word 32'h9AFFFFFF; marker_code=D9; halted=1 and byte_ready=0. After a resume pulse, halted=0 and byte_ready=1.
- Request held low while 12 bytes are offered:
  - byte_ready drops after 8 accepted bytes (hold full plus acc full).
  - Raising request delivers words in order, with valid_out never asserted on consecutive cycles.
- Assert rst while cnt=2 and hold_full=1 -> all outputs are 0 immediately (async). After release, 4 new bytes yield exactly one word.
